// File: rtl/tile_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tile_axi_mem_responder
//
// AXI4 subordinate memory model for the tile's outbound data port. It
// terminates one burst at a time in an internal word-addressed array:
// AW/W/B for writes and AR/R for reads. It supports INCR and FIXED bursts
// (WRAP behaves as INCR), byte-strobed writes, and a programmable read
// latency.
//
// Optional feature macro: TILE_AXI_RESP_SLVERR_EN
//   When defined, a burst whose first or last beat falls outside the served
//   window is still fully handshaken. It writes nothing, reads back zero,
//   and responds SLVERR. When undefined, addresses wrap modulo MEM_WORDS
//   and every response is OKAY.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset (control state only; the
//              array contents survive reset)
//   axi_req_i  AW/W/AR channels plus b_ready/r_ready from the tile
//   axi_rsp_o  aw_ready/w_ready/ar_ready plus the B and R channels
//   busy_o     high whenever a burst is in progress
// ---------------------------------------------------------------------------

package redmule_tile_pkg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_default_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_default_rsp_t;
endpackage

module tile_axi_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned DW        = redmule_tile_pkg::DW
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  redmule_tile_pkg::axi_default_req_t axi_req_i,
  output redmule_tile_pkg::axi_default_rsp_t axi_rsp_o,
  output logic                               busy_o
);

  localparam int unsigned AW    = redmule_tile_pkg::AW;
  localparam int unsigned IW    = redmule_tile_pkg::IW;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam bit          LAT0  = (RD_LAT == 0);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RWAIT, RDATA} state_e;

  state_e state, state_n;

  logic [DW-1:0] mem [MEM_WORDS];

  logic [IW-1:0] id_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic [8:0]    beats_q;
  logic [31:0]   lat_q;
  logic          err_q;
  logic          prio_q;      // 0: write wins a tie, 1: read wins a tie
  logic [DW-1:0] rdata_p1;

  logic          aw_sel, ar_sel, both_valid;
  logic          aw_hs, ar_hs, w_hs, r_hs;
  logic          aw_err, ar_err;
  logic [AW-1:0] addr_nx;
  logic          rd_fetch;
  logic [AW-1:0] fetch_addr;
  logic          fetch_err;

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

`ifdef TILE_AXI_RESP_SLVERR_EN
  localparam logic [AW:0] SPAN = (AW+1)'(MEM_WORDS * NB);

  function automatic logic out_of_range(input logic [AW-1:0] a);
    return {1'b0, a - BASE_ADDR} >= SPAN;
  endfunction

  // Only the first and last beat are checked; the burst is contiguous.
  function automatic logic burst_err(input redmule_tile_pkg::axi_ax_chan_t ax);
    logic [AW-1:0] last_a;
    last_a = (ax.burst == BURST_FIXED) ? ax.addr : ax.addr + (AW'(ax.len) << ax.size);
    return out_of_range(ax.addr) | out_of_range(last_a);
  endfunction

  assign aw_err = burst_err(axi_req_i.aw);
  assign ar_err = burst_err(axi_req_i.ar);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Tie-break between AW and AR; a lone valid always wins.
  assign both_valid = axi_req_i.aw_valid & axi_req_i.ar_valid;
  assign aw_sel = (state == IDLE) && !rst_i && axi_req_i.aw_valid &&
                  (!axi_req_i.ar_valid || !prio_q);
  assign ar_sel = (state == IDLE) && !rst_i && axi_req_i.ar_valid &&
                  (!axi_req_i.aw_valid || prio_q);

  assign aw_hs = aw_sel;
  assign ar_hs = ar_sel;
  assign w_hs  = (state == WDATA) && !rst_i && axi_req_i.w_valid;
  assign r_hs  = (state == RDATA) && axi_req_i.r_ready;

  assign addr_nx = (burst_q == BURST_FIXED) ? addr_q : addr_q + (AW'(1) << size_q);

  // The R data register is refilled on entry to RDATA and after every
  // non-final beat, so r.data only moves on a completed handshake.
  assign rd_fetch   = (state_n == RDATA) && ((state != RDATA) || r_hs);
  assign fetch_addr = (state == IDLE)  ? axi_req_i.ar.addr :
                      (state == RDATA) ? addr_nx : addr_q;
  assign fetch_err  = (state == IDLE) ? ar_err : err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (aw_hs) begin
          state_n = WDATA;
        end else if (ar_hs) begin
          state_n = LAT0 ? RDATA : RWAIT;
        end
      end
      WDATA: begin
        // The beat count terminates the burst even if w.last never comes.
        if (w_hs && (axi_req_i.w.last || beats_q == 9'd1)) begin
          state_n = WRESP;
        end
      end
      WRESP: begin
        if (axi_req_i.b_ready) begin
          state_n = IDLE;
        end
      end
      RWAIT: begin
        if (lat_q <= 32'd1) begin
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (r_hs && beats_q == 9'd1) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_sel;
    axi_rsp_o.ar_ready = ar_sel;
    axi_rsp_o.w_ready  = (state == WDATA) && !rst_i;
    axi_rsp_o.b_valid  = (state == WRESP);
    axi_rsp_o.b.id     = id_q;
    axi_rsp_o.b.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi_rsp_o.r_valid  = (state == RDATA);
    axi_rsp_o.r.id     = id_q;
    axi_rsp_o.r.data   = rdata_p1;
    axi_rsp_o.r.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi_rsp_o.r.last   = (state == RDATA) && (beats_q == 9'd1);
  end

  assign busy_o = (state != IDLE);

  // Burst bookkeeping and registered read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beats_q  <= '0;
      lat_q    <= '0;
      err_q    <= 1'b0;
      prio_q   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      if (aw_hs) begin
        id_q    <= axi_req_i.aw.id;
        addr_q  <= axi_req_i.aw.addr;
        size_q  <= axi_req_i.aw.size;
        burst_q <= axi_req_i.aw.burst;
        beats_q <= 9'(axi_req_i.aw.len) + 9'd1;
        err_q   <= aw_err;
      end else if (ar_hs) begin
        id_q    <= axi_req_i.ar.id;
        addr_q  <= axi_req_i.ar.addr;
        size_q  <= axi_req_i.ar.size;
        burst_q <= axi_req_i.ar.burst;
        beats_q <= 9'(axi_req_i.ar.len) + 9'd1;
        err_q   <= ar_err;
        lat_q   <= 32'(RD_LAT);
      end
      // The tie-break only flips when both channels actually competed.
      if ((aw_hs || ar_hs) && both_valid) begin
        prio_q <= ~prio_q;
      end
      if (w_hs || r_hs) begin
        addr_q  <= addr_nx;
        beats_q <= beats_q - 9'd1;
      end
      if (state == RWAIT) begin
        lat_q <= lat_q - 32'd1;
      end
      if (rd_fetch) begin
        rdata_p1 <= fetch_err ? '0 : mem[word_idx(fetch_addr)];
      end
    end
  end

  // Backing array: never reset, byte-masked writes
  always_ff @(posedge clk_i) begin
    if (w_hs && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_req_i.w.strb[b]) begin
          mem[word_idx(addr_q)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for tile_axi_mem_responder: directed and randomized AXI bursts
// compared against a word-array reference model held in the bench.
// ---------------------------------------------------------------------------
module tb_tile_axi_mem_responder;
  import redmule_tile_pkg::*;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  axi_default_req_t req;
  axi_default_rsp_t rsp;
  logic busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int c0 = 0;

  logic [31:0] model [MW];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] exp_d [16];

  tile_axi_mem_responder #(
    .MEM_WORDS(MW), .BASE_ADDR(BASE), .RD_LAT(LAT), .DW(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_rsp_o(rsp), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: byte addresses map to words relative to BASE, modulo MW.
  function automatic int midx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % MW);
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] size,
                                        input logic [1:0] burst, input int k);
    if (burst == 2'b00) return a;
    return a + 32'(k) * (32'd1 << size);
  endfunction

  function automatic bit model_err(input logic [31:0] a, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
`ifdef TILE_AXI_RESP_SLVERR_EN
    logic [31:0] la;
    la = baddr(a, size, burst, len);
    return ((a - BASE) >= 32'(MW * 4)) || ((la - BASE) >= 32'(MW * 4));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic start_aw(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    req.aw.id = id; req.aw.addr = a; req.aw.len = 8'(len);
    req.aw.size = size; req.aw.burst = burst; req.aw_valid = 1'b1;
  endtask

  task automatic start_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    req.ar.id = id; req.ar.addr = a; req.ar.len = 8'(len);
    req.ar.size = size; req.ar.burst = burst; req.ar_valid = 1'b1;
  endtask

  task automatic finish_aw();
    int n = 0;
    #1;
    while (rsp.aw_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("aw_handshake", 64'(n < 50), 64'(1));
    @(negedge clk);
    req.aw_valid = 1'b0;
  endtask

  task automatic finish_ar();
    int n = 0;
    #1;
    while (rsp.ar_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("ar_handshake", 64'(n < 50), 64'(1));
    c0 = cyc;
    @(negedge clk);
    req.ar_valid = 1'b0;
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    req.b_ready = 1'b0;
    #1;
    while (rsp.b_valid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("b_valid", 64'(n < 50), 64'(1));
    check("b_id", 64'(rsp.b.id), 64'(id));
    check("b_resp", 64'(rsp.b.resp), 64'(resp));
    @(negedge clk); #1;
    check("b_hold", 64'({rsp.b_valid, rsp.b.id}), 64'({1'b1, id}));
    req.b_ready = 1'b1;
    @(negedge clk);
    req.b_ready = 1'b0;
    #1;
    check("b_done", 64'({rsp.b_valid, busy}), 64'(0));
  endtask

  task automatic wr_rest(input logic [3:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit err;
    int n;
    err = model_err(a, len, size, burst);
    finish_aw();
    for (int k = 0; k <= len; k++) begin
      req.w.data = wd[k]; req.w.strb = ws[k]; req.w.last = (k == len); req.w_valid = 1'b1;
      n = 0;
      #1;
      while (rsp.w_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      check("w_ready", 64'(n < 50), 64'(1));
      if (!err) model[midx(baddr(a, size, burst, k))] = merge(model[midx(baddr(a, size, burst, k))], wd[k], ws[k]);
      @(negedge clk);
    end
    req.w_valid = 1'b0;
    req.w.last = 1'b0;
    wait_b(id, err ? 2'b10 : 2'b00);
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] a, input int len,
                    input logic [2:0] size, input logic [1:0] burst);
    start_aw(id, a, len, size, burst);
    wr_rest(id, a, len, size, burst);
  endtask

  task automatic rd_rest(input logic [3:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    bit err;
    int got = 0;
    int n = 0;
    bit first = 1'b1;
    bit have_held = 1'b0;
    logic [31:0] held = '0;
    err = model_err(a, len, size, burst);
    for (int k = 0; k <= len; k++) exp_d[k] = err ? 32'h0 : model[midx(baddr(a, size, burst, k))];
    finish_ar();
    req.r_ready = 1'b0;
    while (got <= len && n < 100) begin
      req.r_ready = stall ? !req.r_ready : 1'b1;
      #1;
      if (rsp.r_valid === 1'b1) begin
        if (first) begin
          check("r_latency", 64'(cyc - c0), 64'(LAT + 1));
          first = 1'b0;
        end
        if (have_held) check("r_hold", 64'(rsp.r.data), 64'(held));
        if (req.r_ready) begin
          check("r_data", 64'(rsp.r.data), 64'(exp_d[got]));
          check("r_last", 64'(rsp.r.last), 64'(got == len));
          check("r_id", 64'(rsp.r.id), 64'(id));
          check("r_resp", 64'(rsp.r.resp), 64'(err ? 2'b10 : 2'b00));
          got++;
          have_held = 1'b0;
        end else begin
          held = rsp.r.data;
          have_held = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    req.r_ready = 1'b0;
    check("r_beats", 64'(got), 64'(len + 1));
    #1;
    check("r_done", 64'({rsp.r_valid, busy}), 64'(0));
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input bit stall);
    start_ar(id, a, len, size, burst);
    rd_rest(id, a, len, size, burst, stall);
  endtask

  initial begin
    int len;
    int word;
    logic [1:0] burst;
    logic [3:0] id;
    logic [31:0] a40;

    req = '0;
    for (int i = 0; i < MW; i++) model[i] = '0;

    // Reset held three cycles with a pending write address
    start_aw(4'h5, BASE + 32'h10, 0, 3'd2, 2'b01);
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_outputs", 64'(rsp), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
    end
    rst = 1'b0;
    #1;
    check("rst_release_aw_ready", 64'(rsp.aw_ready), 64'(1));

    // Single write then read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    wr_rest(4'h5, BASE + 32'h10, 0, 3'd2, 2'b01);
    rd(4'h9, BASE + 32'h10, 0, 3'd2, 2'b01, 1'b0);

    // INCR burst, read back under r_ready backpressure
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    wr(4'h3, BASE, 3, 3'd2, 2'b01);
    rd(4'h4, BASE, 3, 3'd2, 2'b01, 1'b1);

    // Strobed write over a preloaded word
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    wr(4'h1, BASE + 32'h20, 0, 3'd2, 2'b01);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
    wr(4'h2, BASE + 32'h20, 0, 3'd2, 2'b01);
    rd(4'h2, BASE + 32'h20, 0, 3'd2, 2'b01, 1'b0);

    // Preload words 0..31 so random reads only touch written locations
    for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    wr(4'h6, BASE, 15, 3'd2, 2'b01);
    for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    wr(4'h7, BASE + 32'h40, 15, 3'd2, 2'b01);

    // Randomized INCR/FIXED bursts inside the preloaded region
    for (int t = 0; t < 20; t++) begin
      len   = int'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 1));
      word  = int'($urandom_range(0, 31 - len));
      id    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
        wr(id, BASE + 32'(word * 4), len, 3'd2, burst);
      end else begin
        rd(id, BASE + 32'(word * 4), len, 3'd2, burst, 1'($urandom_range(0, 1)));
      end
    end

    // Just past the served window: wraps to word 0, or SLVERR when enabled
    rd(4'hA, BASE + 32'(MW * 4), 1, 3'd2, 2'b01, 1'b0);
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    wr(4'hB, BASE + 32'(MW * 4), 0, 3'd2, 2'b01);
    rd(4'hC, BASE, 0, 3'd2, 2'b01, 1'b0);

    // Arbitration after a fresh reset (memory retained)
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    a40 = BASE + 32'd160;
    start_aw(4'h1, a40, 0, 3'd2, 2'b01);
    start_ar(4'h2, a40, 0, 3'd2, 2'b01);
    #1;
    check("arb1_aw_ready", 64'(rsp.aw_ready), 64'(1));
    check("arb1_ar_ready", 64'(rsp.ar_ready), 64'(0));
    wd[0] = $urandom; ws[0] = 4'hF;
    wr_rest(4'h1, a40, 0, 3'd2, 2'b01);
    rd_rest(4'h2, a40, 0, 3'd2, 2'b01, 1'b0);

    start_aw(4'h3, a40, 0, 3'd2, 2'b01);
    start_ar(4'h4, a40, 0, 3'd2, 2'b01);
    #1;
    check("arb2_ar_ready", 64'(rsp.ar_ready), 64'(1));
    check("arb2_aw_ready", 64'(rsp.aw_ready), 64'(0));
    rd_rest(4'h4, a40, 0, 3'd2, 2'b01, 1'b0);
    wd[0] = $urandom; ws[0] = 4'hF;
    wr_rest(4'h3, a40, 0, 3'd2, 2'b01);
    rd(4'h5, a40, 0, 3'd2, 2'b01, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
